multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM. It sequences a shared-resource datapath (one ALU, one unified instruction/data memory, IR, MDR, A/B, ALUOut) through fetch, decode, execute, memory and writeback.
- It drives all datapath mux selects and write strobes each cycle from the current state and the held IR fields.
- It stalls on a memory ready handshake.
- ALUOp encoding is the same as the single-cycle control decoder, so the existing ALU control is reused unchanged.

Parameters:
- STATE_W, 4, width of state register.
- RST_STATE, 0, encoding of S_FETCH, entered on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- OpCode  in  6  IR[31:26]; held stable by IR outside S_FETCH.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if Zero.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- RegWrite  out  1  register file write.
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31.
- MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC (already PC+4).
- ALUSrcA  out  2  00 = PC, 01 = A, 10 = shamt.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr/jalr).
- ExtOp  out  1  1 = sign extend, 0 = zero extend (andi).
- LuOp  out  1  lui immediate.
- ALUOp  out  4  decoder encoding.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- Exception  out  1  see Optional Feature.

Behaviour:
- Reset: state <= S_FETCH on the clock edge while reset = 1. While reset = 1, all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, retire, Exception) are forced to 0.
- Reset mid-instruction aborts it with no partial writes. The first cycle after reset deasserts is S_FETCH.
- Outputs are combinational from state, OpCode and Funct. IRWrite, PCWrite (in FETCH), retire and state advance in memory states are additionally gated by mem_ready.
- ALUOp is 0000 (add) in FETCH and DECODE. In execute states it is the decoder encoding: R = x010, beq = x001, andi = x100, slti/sltiu = x101, else x000; bit3 = OpCode[0].
- S_FETCH:
  - MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, PCSource=00.
  - If mem_ready: IRWrite=1, PCWrite=1, go to S_DECODE. Otherwise hold with no writes.
- S_DECODE: ALUSrcA=00, ALUSrcB=11 (branch target into ALUOut). Next state:
  - 23 or 2b -> S_MEM_ADDR.
  - 00 with Funct 08/09 -> S_JR.
  - 00 otherwise -> S_EXEC_R.
  - 04 -> S_BRANCH.
  - 02/03 -> S_JUMP.
  - 08/09/0a/0b/0c/0f -> S_EXEC_I.
  - Other -> illegal.
- S_MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ExtOp=1. Go to S_MEM_RD (23) or S_MEM_WR (2b).
- S_MEM_RD: MemRead=1, IorD=1. Hold until mem_ready, then go to S_MEM_WB.
- S_MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01, retire=1. Go to S_FETCH.
- S_MEM_WR: MemWrite=1, IorD=1, held until mem_ready. On mem_ready: retire=1, go to S_FETCH.
- S_EXEC_R: ALUSrcA=10 if Funct is 00/02/03, else 01; ALUSrcB=00. Go to S_ALU_WB.
- S_EXEC_I: ALUSrcA=01, ALUSrcB=10, ExtOp=(OpCode!=0c), LuOp=(OpCode==0f). Go to S_ALU_WB.
- S_ALU_WB: RegWrite=1, MemtoReg=00, RegDst=01 if OpCode==0, else 00. retire=1. Go to S_FETCH.
- S_BRANCH: ALUSrcA=01, ALUSrcB=00, PCWriteCond=1, PCSource=01, retire=1. Go to S_FETCH.
- S_JUMP: PCWrite=1, PCSource=10, retire=1. If 03, also RegWrite=1, RegDst=10, MemtoReg=10. Go to S_FETCH.
- S_JR: PCWrite=1, PCSource=11, retire=1. If Funct 09, also RegWrite=1, RegDst=01, MemtoReg=10. Go to S_FETCH.
- Invariants:
  - MemRead and MemWrite are never both high.
  - Memory states never assert RegWrite/PCWrite while waiting.
  - Unused encodings go to S_FETCH.
- CPI: beq/j/jr 3; R/I 4; sw 4; lw 5 (plus wait cycles).

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE goes to S_TRAP.
  - S_TRAP asserts Exception=1 and PCWrite=1 for one cycle. The datapath loads vector 32'h0000_0080 when Exception=1.
  - No RegWrite and no retire in S_TRAP. Go to S_FETCH.
- Not defined: illegal opcode goes DECODE -> S_FETCH as a NOP with retire=1. Exception is tied 0.

Decomposition:
- Package multicycle_pkg:
  - State encodings S_FETCH..S_TRAP.
  - Opcode/funct constants.
  - ALUOp encodings.
  - Select encodings for RegDst, MemtoReg, ALUSrcA/B, PCSource.
- Sub-module mc_aluop_decode: combinational OpCode -> ALUOp, shared with the single-cycle flow.

Test Plan:
- reset held 3 cycles during S_MEM_WR -> MemWrite=0 throughout reset; state=S_FETCH and MemRead=1 the first cycle after release.
- add $3,$1,$2 (OpCode 00, Funct 20), mem_ready=1 -> 4 cycles; S_ALU_WB has RegWrite=1, RegDst=01, ALUOp=0010; retire pulses once.
- lw (23) with mem_ready low for 2 cycles in S_MEM_RD -> MemRead/IorD=1 held, no RegWrite. S_MEM_WB follows ready; total 7 cycles; MemtoReg=01.
- beq (04) with Zero=1 and Zero=0 -> PCWriteCond=1, PCSource=01, ALUOp=0001 in both cases; 3 cycles.
- jal (03) then jr (00/08) -> first: PCWrite, PCSource=10, RegDst=10, MemtoReg=10. Second: PCSource=11, RegWrite=0.
- OpCode 3f -> with MULTICYCLE_ILLEGAL_TRAP_EN: Exception=1 and PCWrite=1 for exactly one cycle, retire=0. Without it: DECODE -> FETCH, retire=1, Exception=0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// FSM states, opcode/funct values, ALUOp and datapath select codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // low three ALUOp bits; bit3 carries OpCode[0]
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_A     = 2'b01;
  localparam logic [1:0] SA_SHAMT = 2'b10;

  localparam logic [1:0] SB_B    = 2'b00;
  localparam logic [1:0] SB_4    = 2'b01;
  localparam logic [1:0] SB_IMM  = 2'b10;
  localparam logic [1:0] SB_IMM2 = 2'b11;

  localparam logic [1:0] PS_ALU    = 2'b00;
  localparam logic [1:0] PS_ALUOUT = 2'b01;
  localparam logic [1:0] PS_JUMP   = 2'b10;
  localparam logic [1:0] PS_REG    = 2'b11;

endpackage

// File: rtl/mc_aluop_decode.sv
// OpCode -> ALUOp decoder, same encoding as the single-cycle flow
// so the downstream ALU control block is reused unchanged.
module mc_aluop_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] OpCode,
  output logic [3:0] ALUOp
);

  logic [2:0] base;

  // classify the opcode into an ALU operation group
  always_comb begin
    base = ALU_ADD;
    case (OpCode)
      OP_RTYPE: base = ALU_R;
      OP_BEQ:   base = ALU_SUB;
      OP_ANDI:  base = ALU_AND;
      OP_SLTI,
      OP_SLTIU: base = ALU_SLT;
      default:  base = ALU_ADD;
    endcase
  end

  assign ALUOp = {OpCode[0], base};

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory ready stalls.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap illegal opcodes.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int STATE_W   = 4,
  parameter int RST_STATE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [3:0] ALUOp,
  output logic       retire,
  output logic       Exception
);

  logic [STATE_W-1:0] state_r;
  state_t state;
  state_t next;
  logic [3:0] dec_aluop;
  logic is_mem, is_jr, is_r;
  logic is_beq, is_j, is_i;
  logic is_shift;
  logic unused_zero;

  // branch condition is resolved in the datapath
  assign unused_zero = Zero;

  assign state = state_t'(state_r[3:0]);

  mc_aluop_decode u_dec (
    .OpCode (OpCode),
    .ALUOp  (dec_aluop)
  );

  assign is_mem = (OpCode == OP_LW) || (OpCode == OP_SW);
  assign is_jr = (OpCode == OP_RTYPE) &&
                 ((Funct == FN_JR) || (Funct == FN_JALR));
  assign is_r = (OpCode == OP_RTYPE) && !is_jr;
  assign is_beq = (OpCode == OP_BEQ);
  assign is_j = (OpCode == OP_J) || (OpCode == OP_JAL);
  assign is_i = (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) ||
                (OpCode == OP_SLTI) || (OpCode == OP_SLTIU) ||
                (OpCode == OP_ANDI) || (OpCode == OP_LUI);
  assign is_shift = (Funct == FN_SLL) || (Funct == FN_SRL) ||
                    (Funct == FN_SRA);

  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) state_r <= STATE_W'(RST_STATE);
    else       state_r <= STATE_W'(next);
  end

  // next state and per-state datapath controls
  always_comb begin
    next        = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = RD_RT;
    MemtoReg    = M2R_ALU;
    ALUSrcA     = SA_PC;
    ALUSrcB     = SB_B;
    PCSource    = PS_ALU;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    ALUOp       = dec_aluop;
    retire      = 1'b0;
    Exception   = 1'b0;
    unique case (state)
      S_FETCH: begin
        ALUOp   = 4'b0000;
        MemRead = 1'b1;
        ALUSrcB = SB_4;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          next    = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUOp   = 4'b0000;
        ALUSrcB = SB_IMM2;
        unique case (1'b1)
          is_mem: next = S_MEM_ADDR;
          is_jr:  next = S_JR;
          is_r:   next = S_EXEC_R;
          is_beq: next = S_BRANCH;
          is_j:   next = S_JUMP;
          is_i:   next = S_EXEC_I;
          default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            next = S_TRAP;
`else
            next   = S_FETCH;
            retire = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = SA_A;
        ALUSrcB = SB_IMM;
        ExtOp   = 1'b1;
        next    = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) next = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
        retire   = 1'b1;
        next     = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          next   = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = is_shift ? SA_SHAMT : SA_A;
        next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA = SA_A;
        ALUSrcB = SB_IMM;
        ExtOp   = (OpCode != OP_ANDI);
        LuOp    = (OpCode == OP_LUI);
        next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = (OpCode == OP_RTYPE) ? RD_RD : RD_RT;
        retire   = 1'b1;
        next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = SA_A;
        PCWriteCond = 1'b1;
        PCSource    = PS_ALUOUT;
        retire      = 1'b1;
        next        = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PS_JUMP;
        retire   = 1'b1;
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = RD_RA;
          MemtoReg = M2R_PC;
        end
        next = S_FETCH;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PS_REG;
        retire   = 1'b1;
        if (Funct == FN_JALR) begin
          RegWrite = 1'b1;
          RegDst   = RD_RD;
          MemtoReg = M2R_PC;
        end
        next = S_FETCH;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        Exception = 1'b1;
        PCWrite   = 1'b1;
        next      = S_FETCH;
      end
`endif
      default: next = S_FETCH;
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      retire      = 1'b0;
      Exception   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected
// controls are queued with stimulus and compared at negedge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       Zero, mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, RegWrite, ExtOp, LuOp, retire, Exception;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] regdst;
    logic [1:0] m2r;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       ext;
    logic       lu;
    logic [3:0] aluop;
    logic       ret;
    logic       exc;
  } ov_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
    ov_t        exp;
  } ent_t;

  ent_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ExtOp(ExtOp),
    .LuOp(LuOp), .ALUOp(ALUOp), .retire(retire),
    .Exception(Exception)
  );

  function automatic ov_t act();
    ov_t v;
    v = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
         RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
         ExtOp, LuOp, ALUOp, retire, Exception};
    return v;
  endfunction

  function automatic ov_t e_fetch(input logic rdy);
    ov_t v = '0;
    v.mr = 1'b1; v.srcb = 2'b01;
    v.irw = rdy; v.pcw = rdy;
    return v;
  endfunction

  function automatic ov_t e_decode(input logic nop);
    ov_t v = '0;
    v.srcb = 2'b11; v.ret = nop;
    return v;
  endfunction

  function automatic ov_t e_mem_addr(input logic [3:0] a);
    ov_t v = '0;
    v.srca = 2'b01; v.srcb = 2'b10; v.ext = 1'b1; v.aluop = a;
    return v;
  endfunction

  function automatic ov_t e_mem_rd(input logic [3:0] a);
    ov_t v = '0;
    v.mr = 1'b1; v.iord = 1'b1; v.aluop = a;
    return v;
  endfunction

  function automatic ov_t e_mem_wb(input logic [3:0] a);
    ov_t v = '0;
    v.rw = 1'b1; v.m2r = 2'b01; v.ret = 1'b1; v.aluop = a;
    return v;
  endfunction

  function automatic ov_t e_mem_wr(input logic rdy, input logic [3:0] a);
    ov_t v = '0;
    v.mw = 1'b1; v.iord = 1'b1; v.ret = rdy; v.aluop = a;
    return v;
  endfunction

  function automatic ov_t e_exec_r(input logic [1:0] sa, input logic [3:0] a);
    ov_t v = '0;
    v.srca = sa; v.aluop = a;
    return v;
  endfunction

  function automatic ov_t e_exec_i(input logic e, input logic l, input logic [3:0] a);
    ov_t v = '0;
    v.srca = 2'b01; v.srcb = 2'b10;
    v.ext = e; v.lu = l; v.aluop = a;
    return v;
  endfunction

  function automatic ov_t e_alu_wb(input logic [1:0] rd, input logic [3:0] a);
    ov_t v = '0;
    v.rw = 1'b1; v.regdst = rd; v.ret = 1'b1; v.aluop = a;
    return v;
  endfunction

  function automatic ov_t e_branch(input logic [3:0] a);
    ov_t v = '0;
    v.srca = 2'b01; v.pcwc = 1'b1; v.pcsrc = 2'b01;
    v.ret = 1'b1; v.aluop = a;
    return v;
  endfunction

  function automatic ov_t e_jump(input logic link, input logic [3:0] a);
    ov_t v = '0;
    v.pcw = 1'b1; v.pcsrc = 2'b10; v.ret = 1'b1; v.aluop = a;
    if (link) begin
      v.rw = 1'b1; v.regdst = 2'b10; v.m2r = 2'b10;
    end
    return v;
  endfunction

  function automatic ov_t e_jr(input logic link, input logic [3:0] a);
    ov_t v = '0;
    v.pcw = 1'b1; v.pcsrc = 2'b11; v.ret = 1'b1; v.aluop = a;
    if (link) begin
      v.rw = 1'b1; v.regdst = 2'b01; v.m2r = 2'b10;
    end
    return v;
  endfunction

  function automatic ov_t e_trap(input logic [3:0] a);
    ov_t v = '0;
    v.exc = 1'b1; v.pcw = 1'b1; v.aluop = a;
    return v;
  endfunction

  function automatic ov_t mask(input ov_t i);
    ov_t v = i;
    v.pcw = 1'b0; v.pcwc = 1'b0; v.mr = 1'b0; v.mw = 1'b0;
    v.irw = 1'b0; v.rw = 1'b0; v.ret = 1'b0; v.exc = 1'b0;
    return v;
  endfunction

  task automatic push(input logic r, input logic rdy, input logic z,
                      input logic [5:0] op, input logic [5:0] fn,
                      input ov_t e);
    ent_t t;
    t.rst = r; t.rdy = rdy; t.z = z; t.op = op; t.fn = fn; t.exp = e;
    sb.push_back(t);
  endtask

  task automatic test_reset();
    ent_t e;
    ov_t  g;
    int   c = 0;
    push(1, 0, 0, 6'h2b, 0, mask(e_fetch(0)));
    push(0, 1, 0, 6'h2b, 0, e_fetch(1));
    push(0, 0, 0, 6'h2b, 0, e_decode(0));
    push(0, 0, 0, 6'h2b, 0, e_mem_addr(4'b1000));
    push(0, 0, 0, 6'h2b, 0, e_mem_wr(0, 4'b1000));
    push(1, 1, 0, 6'h2b, 0, mask(e_mem_wr(1, 4'b1000)));
    push(1, 1, 0, 6'h2b, 0, mask(e_fetch(1)));
    push(1, 1, 0, 6'h2b, 0, mask(e_fetch(1)));
    push(0, 0, 0, 6'h2b, 0, e_fetch(0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.rdy; Zero = e.z;
      OpCode = e.op; Funct = e.fn;
      @(negedge clk);
      g = act();
      n_vec++;
      if (g !== e.exp) begin
        n_err++;
        $display("FAIL reset cyc%0d got=%h exp=%h", c, g, e.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    ent_t e;
    ov_t  g;
    int   c = 0;
    int   rc = 0;
    push(0, 1, 0, 6'h00, 6'h20, e_fetch(1));
    push(0, 0, 0, 6'h00, 6'h20, e_decode(0));
    push(0, 0, 0, 6'h00, 6'h20, e_exec_r(2'b01, 4'b0010));
    push(0, 0, 0, 6'h00, 6'h20, e_alu_wb(2'b01, 4'b0010));
    push(0, 1, 0, 6'h0c, 0, e_fetch(1));
    push(0, 0, 0, 6'h0c, 0, e_decode(0));
    push(0, 0, 0, 6'h0c, 0, e_exec_i(0, 0, 4'b0100));
    push(0, 0, 0, 6'h0c, 0, e_alu_wb(2'b00, 4'b0100));
    push(0, 1, 0, 6'h0f, 0, e_fetch(1));
    push(0, 0, 0, 6'h0f, 0, e_decode(0));
    push(0, 0, 0, 6'h0f, 0, e_exec_i(1, 1, 4'b1000));
    push(0, 0, 0, 6'h0f, 0, e_alu_wb(2'b00, 4'b1000));
    push(0, 1, 0, 6'h0b, 0, e_fetch(1));
    push(0, 0, 0, 6'h0b, 0, e_decode(0));
    push(0, 0, 0, 6'h0b, 0, e_exec_i(1, 0, 4'b1101));
    push(0, 0, 0, 6'h0b, 0, e_alu_wb(2'b00, 4'b1101));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.rdy; Zero = e.z;
      OpCode = e.op; Funct = e.fn;
      @(negedge clk);
      g = act();
      if (c < 4 && retire === 1'b1) rc++;
      n_vec++;
      if (g !== e.exp) begin
        n_err++;
        $display("FAIL alu cyc%0d got=%h exp=%h", c, g, e.exp);
      end
      c++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (rc !== 1) begin
      n_err++;
      $display("FAIL add_retire_count got=%0d exp=1", rc);
    end
  endtask

  task automatic test_mem();
    ent_t e;
    ov_t  g;
    int   c = 0;
    push(0, 1, 0, 6'h23, 0, e_fetch(1));
    push(0, 0, 0, 6'h23, 0, e_decode(0));
    push(0, 0, 0, 6'h23, 0, e_mem_addr(4'b1000));
    push(0, 0, 0, 6'h23, 0, e_mem_rd(4'b1000));
    push(0, 0, 0, 6'h23, 0, e_mem_rd(4'b1000));
    push(0, 1, 0, 6'h23, 0, e_mem_rd(4'b1000));
    push(0, 0, 0, 6'h23, 0, e_mem_wb(4'b1000));
    push(0, 1, 0, 6'h2b, 0, e_fetch(1));
    push(0, 0, 0, 6'h2b, 0, e_decode(0));
    push(0, 0, 0, 6'h2b, 0, e_mem_addr(4'b1000));
    push(0, 1, 0, 6'h2b, 0, e_mem_wr(1, 4'b1000));
    push(0, 0, 0, 6'h00, 0, e_fetch(0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.rdy; Zero = e.z;
      OpCode = e.op; Funct = e.fn;
      @(negedge clk);
      g = act();
      n_vec++;
      if (g !== e.exp) begin
        n_err++;
        $display("FAIL mem cyc%0d got=%h exp=%h", c, g, e.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    ent_t e;
    ov_t  g;
    int   c = 0;
    push(0, 1, 1, 6'h04, 0, e_fetch(1));
    push(0, 0, 1, 6'h04, 0, e_decode(0));
    push(0, 0, 1, 6'h04, 0, e_branch(4'b0001));
    push(0, 1, 0, 6'h04, 0, e_fetch(1));
    push(0, 0, 0, 6'h04, 0, e_decode(0));
    push(0, 0, 0, 6'h04, 0, e_branch(4'b0001));
    push(0, 1, 0, 6'h03, 0, e_fetch(1));
    push(0, 0, 0, 6'h03, 0, e_decode(0));
    push(0, 0, 0, 6'h03, 0, e_jump(1, 4'b1000));
    push(0, 1, 0, 6'h00, 6'h08, e_fetch(1));
    push(0, 0, 0, 6'h00, 6'h08, e_decode(0));
    push(0, 0, 0, 6'h00, 6'h08, e_jr(0, 4'b0010));
    push(0, 1, 0, 6'h00, 6'h09, e_fetch(1));
    push(0, 0, 0, 6'h00, 6'h09, e_decode(0));
    push(0, 0, 0, 6'h00, 6'h09, e_jr(1, 4'b0010));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.rdy; Zero = e.z;
      OpCode = e.op; Funct = e.fn;
      @(negedge clk);
      g = act();
      n_vec++;
      if (g !== e.exp) begin
        n_err++;
        $display("FAIL brj cyc%0d got=%h exp=%h", c, g, e.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    ov_t  g;
    int   c = 0;
    push(0, 1, 0, 6'h3f, 0, e_fetch(1));
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    push(0, 0, 0, 6'h3f, 0, e_decode(0));
    push(0, 0, 0, 6'h3f, 0, e_trap(4'b1000));
`else
    push(0, 0, 0, 6'h3f, 0, e_decode(1));
`endif
    push(0, 0, 0, 6'h3f, 0, e_fetch(0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.rdy; Zero = e.z;
      OpCode = e.op; Funct = e.fn;
      @(negedge clk);
      g = act();
      n_vec++;
      if (g !== e.exp) begin
        n_err++;
        $display("FAIL illegal cyc%0d got=%h exp=%h", c, g, e.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    ov_t  g;
    int   c = 0;
    push(0, 1, 0, 6'h00, 6'h00, e_fetch(1));
    push(0, 0, 0, 6'h00, 6'h00, e_decode(0));
    push(0, 0, 0, 6'h00, 6'h00, e_exec_r(2'b10, 4'b0010));
    push(0, 0, 0, 6'h00, 6'h00, e_alu_wb(2'b01, 4'b0010));
    push(0, 1, 0, 6'h02, 0, e_fetch(1));
    push(0, 0, 0, 6'h02, 0, e_decode(0));
    push(0, 0, 0, 6'h02, 0, e_jump(0, 4'b0000));
    push(0, 0, 0, 6'h09, 0, e_fetch(0));
    push(0, 1, 0, 6'h09, 0, e_fetch(1));
    push(0, 0, 0, 6'h09, 0, e_decode(0));
    push(0, 0, 0, 6'h09, 0, e_exec_i(1, 0, 4'b1000));
    push(0, 0, 0, 6'h09, 0, e_alu_wb(2'b00, 4'b1000));
    push(0, 0, 0, 6'h00, 0, e_fetch(0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.rdy; Zero = e.z;
      OpCode = e.op; Funct = e.fn;
      @(negedge clk);
      g = act();
      n_vec++;
      if (g !== e.exp) begin
        n_err++;
        $display("FAIL b2b cyc%0d got=%h exp=%h", c, g, e.exp);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; Zero = 1'b0;
    OpCode = 6'h00; Funct = 6'h00;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_mem();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
